viterbi_traceback: RTL and testbench

Survivor-path reader for the 32-state Viterbi decoder. Accepts one 32-bit decision word per trellis step from the ACS stage, stores it in a 64-entry circular buffer, and periodically traces back from a start state to recover decoded bits. Emits a 16-bit block per traceback, oldest bit first, and sits between the ACS/path-metric stage and the downstream bit sink.

---
 rtl/vtb_pkg.sv | 29 ++
 rtl/vtb_lifo_out.sv | 44 ++++
 rtl/viterbi_traceback.sv | 133 +++++++++++++
 tb/tb_viterbi_traceback.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vtb_pkg.sv
// Shared types, sizes and the trellis predecessor helper for the Viterbi traceback unit.
package vtb_pkg;
  localparam int STATE_W    = 5;
  localparam int NUM_STATES = 32;
  localparam int TB_LEN     = 16;
  localparam int DEC_LEN    = 16;
  localparam int MEM_DEPTH  = 64;

  localparam int ADDR_W    = $clog2(MEM_DEPTH);
  localparam int STEP_W    = $clog2(TB_LEN + DEC_LEN);
  localparam int ACC_W     = $clog2(TB_LEN + DEC_LEN);
  localparam int DEC_IDX_W = $clog2(DEC_LEN);
  localparam int OUT_CNT_W = $clog2(DEC_LEN + 1);

  typedef logic [STATE_W-1:0] state_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACE = 2'd1,
    LOAD  = 2'd2
  } fsm_t;

  // The survivor decision for a state supplies the bit shifted out of the
  // state register, so it becomes the new MSB of the predecessor.
  function automatic state_t vtb_pred(input state_t state,
                                      input logic [NUM_STATES-1:0] dec_word);
    return {dec_word[state], state[STATE_W-1:1]};
  endfunction
endpackage

// File: rtl/vtb_lifo_out.sv
// Output stage: loads a decoded block and shifts it out MSB first, one bit per
// cycle. Runs independently of the traceback FSM so a new trace can overlap it.
module vtb_lifo_out
  import vtb_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [DEC_LEN-1:0] load_data,
  output logic               bit_out,
  output logic               bit_valid
);

  logic [DEC_LEN-1:0]   out_sr_q, out_sr_d;
  logic [OUT_CNT_W-1:0] out_cnt_q, out_cnt_d;

  // Next-state: load a full block, otherwise shift while bits remain.
  always_comb begin
    out_sr_d  = out_sr_q;
    out_cnt_d = out_cnt_q;
    if (load) begin
      out_sr_d  = load_data;
      out_cnt_d = OUT_CNT_W'(DEC_LEN);
    end else if (out_cnt_q != '0) begin
      out_sr_d  = {out_sr_q[DEC_LEN-2:0], 1'b0};
      out_cnt_d = out_cnt_q - OUT_CNT_W'(1);
    end
  end

  // Shift register and remaining-bit counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_sr_q  <= '0;
      out_cnt_q <= '0;
    end else begin
      out_sr_q  <= out_sr_d;
      out_cnt_q <= out_cnt_d;
    end
  end

  assign bit_valid = (out_cnt_q != '0);
  assign bit_out   = out_sr_q[DEC_LEN-1] & bit_valid;

endmodule

// File: rtl/viterbi_traceback.sv
// Survivor-path reader for the 32-state Viterbi decoder: stores one decision
// word per trellis step in a 64-entry circular buffer and traces back
// TB_LEN+DEC_LEN steps every DEC_LEN accepted words, emitting DEC_LEN bits
// oldest first.
// Optional feature macro: VTB_BEST_STATE_EN (adds best_state input as the
// traceback start state; otherwise tracing starts from state 0).
//
// state | meaning
// IDLE  | waiting for a trigger word
// TRACE | walking back one step per cycle, capturing the last DEC_LEN bits
// LOAD  | handing the captured block to the output stage
module viterbi_traceback
  import vtb_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  dec_valid,
  output logic                  dec_ready,
  input  logic [NUM_STATES-1:0] dec_word,
`ifdef VTB_BEST_STATE_EN
  input  logic [STATE_W-1:0]    best_state,
`endif
  output logic                  bit_out,
  output logic                  bit_valid,
  output logic                  busy
);

  localparam logic [ACC_W-1:0]  ACC_LAST  = ACC_W'(TB_LEN + DEC_LEN - 1);
  localparam logic [ACC_W-1:0]  ACC_REARM = ACC_W'(TB_LEN);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(TB_LEN + DEC_LEN - 1);

  logic [NUM_STATES-1:0] mem_q [MEM_DEPTH];

  logic [ADDR_W-1:0]  wp_q, wp_d;
  logic [ACC_W-1:0]   acc_cnt_q, acc_cnt_d;
  fsm_t               fsm_q, fsm_d;
  logic [STEP_W-1:0]  step_q, step_d;
  logic [ADDR_W-1:0]  tb_addr_q, tb_addr_d;
  state_t             tb_state_q, tb_state_d;
  logic [DEC_LEN-1:0] dec_buf_q, dec_buf_d;

  logic                  trig_next, accept, trigger;
  logic [NUM_STATES-1:0] rd_word;
  logic [DEC_IDX_W-1:0]  dec_idx;
  state_t                start_state;

`ifdef VTB_BEST_STATE_EN
  assign start_state = best_state;
`else
  assign start_state = '0;
`endif

  // acc_cnt re-arms to TB_LEN after a trigger, so every trigger sits at ACC_LAST.
  // Holding off the trigger word while tracing caps writes during a trace at
  // DEC_LEN-1, keeping the 32 words under traceback intact.
  assign trig_next = (acc_cnt_q == ACC_LAST);
  assign dec_ready = !((fsm_q != IDLE) && trig_next);
  assign accept    = dec_valid && dec_ready;
  assign trigger   = accept && trig_next;
  assign rd_word   = mem_q[tb_addr_q];
  assign dec_idx   = DEC_IDX_W'(step_q - STEP_W'(TB_LEN));
  assign busy      = (fsm_q != IDLE);

  // Write side, trigger bookkeeping and traceback sequencing.
  always_comb begin
    wp_d       = wp_q;
    acc_cnt_d  = acc_cnt_q;
    fsm_d      = fsm_q;
    step_d     = step_q;
    tb_addr_d  = tb_addr_q;
    tb_state_d = tb_state_q;
    dec_buf_d  = dec_buf_q;
    if (accept) begin
      wp_d      = wp_q + ADDR_W'(1);
      acc_cnt_d = trig_next ? ACC_REARM : acc_cnt_q + ACC_W'(1);
    end
    case (fsm_q)
      IDLE: begin
        if (trigger) begin
          fsm_d      = TRACE;
          step_d     = '0;
          tb_addr_d  = wp_q;
          tb_state_d = start_state;
        end
      end
      TRACE: begin
        if (step_q >= STEP_W'(TB_LEN)) dec_buf_d[dec_idx] = tb_state_q[0];
        tb_state_d = vtb_pred(tb_state_q, rd_word);
        tb_addr_d  = tb_addr_q - ADDR_W'(1);
        step_d     = step_q + STEP_W'(1);
        if (step_q == STEP_LAST) fsm_d = LOAD;
      end
      LOAD:    fsm_d = IDLE;
      default: fsm_d = IDLE;
    endcase
  end

  // Control and traceback registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp_q       <= '0;
      acc_cnt_q  <= '0;
      fsm_q      <= IDLE;
      step_q     <= '0;
      tb_addr_q  <= '0;
      tb_state_q <= '0;
      dec_buf_q  <= '0;
    end else begin
      wp_q       <= wp_d;
      acc_cnt_q  <= acc_cnt_d;
      fsm_q      <= fsm_d;
      step_q     <= step_d;
      tb_addr_q  <= tb_addr_d;
      tb_state_q <= tb_state_d;
      dec_buf_q  <= dec_buf_d;
    end
  end

  // Decision buffer; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (accept) mem_q[wp_q] <= dec_word;
  end

  vtb_lifo_out u_lifo_out (
    .clk       (clk),
    .rst       (rst),
    .load      (fsm_q == LOAD),
    .load_data (dec_buf_q),
    .bit_out   (bit_out),
    .bit_valid (bit_valid)
  );

endmodule

// File: tb/tb_viterbi_traceback.sv
// Self-checking bench for viterbi_traceback (optionally with VTB_BEST_STATE_EN).
module tb_viterbi_traceback;
  logic        clk = 1'b0;
  logic        rst;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_word;
`ifdef VTB_BEST_STATE_EN
  logic [4:0]  best_state;
`endif
  logic        bit_out;
  logic        bit_valid;
  logic        busy;

  always #5 clk = ~clk;

  viterbi_traceback dut (
    .clk        (clk),
    .rst        (rst),
    .dec_valid  (dec_valid),
    .dec_ready  (dec_ready),
    .dec_word   (dec_word),
`ifdef VTB_BEST_STATE_EN
    .best_state (best_state),
`endif
    .bit_out    (bit_out),
    .bit_valid  (bit_valid),
    .busy       (busy)
  );

  int          n_assert = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          busy_end = -1;
  logic [31:0] hist[$];
  logic        exp_bit[int];
  logic        obs_q[$];
  int          trig_q[$];
  int          fall_q[$];
  int          rise_q[$];
  int          vstart_q[$];
  logic        prev_ready = 1'b1;
  logic        prev_valid = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Index of the next accepted word decides whether it triggers.
  function automatic bit next_is_trig();
    int n = hist.size();
    return (n == 31) || (n > 31 && ((n - 31) % 16) == 0);
  endfunction

  function automatic logic [4:0] cur_start();
`ifdef VTB_BEST_STATE_EN
    return best_state;
`else
    return 5'd0;
`endif
  endfunction

  // Walk the survivor history back 32 steps from word n; b[15] is emitted first.
  function automatic logic [15:0] model_block(input int n, input logic [4:0] s0);
    logic [4:0]  s = s0;
    logic [15:0] b = '0;
    logic [31:0] w;
    for (int k = 0; k < 32; k++) begin
      w = hist[n - k];
      if (k >= 16) b[k - 16] = s[0];
      s = {w[s], s[4:1]};
    end
    return b;
  endfunction

  task automatic sample();
    logic eb, er, ev;
    eb = (cyc <= busy_end);
    er = !(eb && next_is_trig());
    ev = exp_bit.exists(cyc);
    check("busy", 32'(busy), 32'(eb));
    check("dec_ready", 32'(dec_ready), 32'(er));
    check("bit_valid", 32'(bit_valid), 32'(ev));
    if (ev) check("bit_out", 32'(bit_out), 32'(exp_bit[cyc]));
    if (bit_valid === 1'b1) obs_q.push_back(bit_out);
    if (prev_ready && !dec_ready) fall_q.push_back(cyc);
    if (!prev_ready && dec_ready) rise_q.push_back(cyc);
    if (!prev_valid && bit_valid) vstart_q.push_back(cyc);
    prev_ready = dec_ready;
    prev_valid = bit_valid;
  endtask

  task automatic tick(input logic v, input logic [31:0] w, output logic acc);
    logic        trig;
    logic [15:0] blk;
    sample();
    dec_valid = v;
    dec_word  = w;
    acc = v && !((cyc <= busy_end) && next_is_trig());
    if (acc) begin
      trig = next_is_trig();
      hist.push_back(w);
      if (trig) begin
        blk = model_block(hist.size() - 1, cur_start());
        for (int i = 0; i < 16; i++) exp_bit[cyc + 34 + i] = blk[15 - i];
        busy_end = cyc + 33;
        trig_q.push_back(cyc);
      end
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) tick(1'b0, $urandom, acc);
  endtask

  task automatic push(input logic [31:0] w);
    logic acc;
    int   tries = 0;
    do begin
      tick(1'b1, w, acc);
      tries++;
    end while (!acc && tries < 60);
    n_assert++;
    assert (tries < 60) else begin
      n_fail++;
      $error("FAIL push_timeout observed=%0d expected=<60", tries);
    end
  endtask

  task automatic clear_obs();
    obs_q.delete(); trig_q.delete(); fall_q.delete(); rise_q.delete(); vstart_q.delete();
  endtask

  task automatic do_reset();
    sample();
    rst = 1'b0;
    dec_valid = 1'b0;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(dec_ready), 32'd1);
    check("rst_valid", 32'(bit_valid), 32'd0);
    check("rst_bit", 32'(bit_out), 32'd0);
    hist.delete();
    exp_bit.delete();
    busy_end = -1;
    clear_obs();
    prev_ready = 1'b1;
    prev_valid = 1'b0;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    rst = 1'b1;
  endtask

  logic [47:0] u;
  logic [4:0]  s_n;
  logic [31:0] w;
  logic [15:0] v1, v2;
  logic        acc;
  int          t_trace;
  int          n_words;
  int          guard;

  initial begin
    rst = 1'b0; dec_valid = 1'b0; dec_word = '0;
`ifdef VTB_BEST_STATE_EN
    best_state = 5'd0;
`endif
    repeat (3) @(negedge clk);
    check("init_busy", 32'(busy), 32'd0);
    check("init_ready", 32'(dec_ready), 32'd1);
    check("init_valid", 32'(bit_valid), 32'd0);
    check("init_bit", 32'(bit_out), 32'd0);
    rst = 1'b1;
    cyc = 0;

    // All-zero decisions from state 0.
    for (int i = 0; i < 32; i++) push(32'h0);
    idle(55);
    check("zero_nbits", 32'(obs_q.size()), 32'd16);
    v1 = '1;
    for (int i = 0; i < 16 && i < obs_q.size(); i++) v1[i] = obs_q[i];
    check("zero_block", 32'(v1), 32'h0);
    if (trig_q.size() > 0 && vstart_q.size() > 0)
      check("zero_latency", 32'(vstart_q[0] - trig_q[0]), 32'd34);
    else check("zero_latency_seen", 32'(vstart_q.size()), 32'd1);

    // All-ones decisions from state 0 saturate at state 31.
    do_reset();
`ifdef VTB_BEST_STATE_EN
    best_state = 5'd0;
`endif
    for (int i = 0; i < 32; i++) push(32'hFFFF_FFFF);
    idle(55);
    check("ones_nbits", 32'(obs_q.size()), 32'd16);
    v1 = '0;
    for (int i = 0; i < 16 && i < obs_q.size(); i++) v1[i] = obs_q[i];
    check("ones_block", 32'(v1), 32'hFFFF);

    // Known sequence encoded into ideal decisions, streamed continuously.
    do_reset();
    u = {$urandom, $urandom};
    u[31:27] = '0;
    u[47:43] = '0;
    for (int n = 0; n < 48; n++) begin
      for (int j = 0; j < 5; j++) s_n[j] = (n - j >= 0) ? u[n - j] : 1'b0;
      w = $urandom;
      w[s_n] = (n >= 5) ? u[n - 5] : 1'b0;
`ifdef VTB_BEST_STATE_EN
      best_state = s_n;
`endif
      push(w);
    end
    idle(60);
    check("seq_nbits", 32'(obs_q.size()), 32'd32);
    v1 = '0; v2 = '0;
    for (int i = 0; i < 16 && i < obs_q.size(); i++) v1[i] = obs_q[i];
    for (int i = 0; i < 16 && i + 16 < obs_q.size(); i++) v2[i] = obs_q[16 + i];
    check("seq_block0", 32'(v1), 32'(u[15:0]));
    check("seq_block1", 32'(v2), 32'(u[31:16]));
    check("seq_nfall", 32'(fall_q.size()), 32'd1);
    check("seq_nrise", 32'(rise_q.size()), 32'd1);
    if (trig_q.size() > 0 && fall_q.size() > 0)
      check("seq_ready_fall", 32'(fall_q[0] - trig_q[0]), 32'd16);
    if (trig_q.size() > 0 && rise_q.size() > 0)
      check("seq_ready_rise", 32'(rise_q[0] - trig_q[0]), 32'd34);

    // Random words with random gaps, long enough to wrap the write pointer.
    do_reset();
    n_words = 0;
    guard = 0;
    while (n_words < 200 && guard < 2000) begin
`ifdef VTB_BEST_STATE_EN
      best_state = 5'($urandom);
`endif
      tick(($urandom % 4) != 0, $urandom, acc);
      if (acc) n_words++;
      guard++;
    end
    check("wrap_words", 32'(n_words), 32'd200);
    idle(60);
    check("wrap_nbits", 32'(obs_q.size()), 32'(16 * trig_q.size()));

    // Reset during TRACE at step 10.
    do_reset();
    for (int i = 0; i < 32; i++) push($urandom);
    t_trace = (trig_q.size() > 0) ? trig_q[0] : cyc;
    guard = 0;
    while (cyc < t_trace + 11 && guard < 100) begin idle(1); guard++; end
    do_reset();
    idle(60);
    check("abort_trace_nbits", 32'(obs_q.size()), 32'd0);

    // Reset during output at bit 5, then a fresh fill.
    for (int i = 0; i < 32; i++) push($urandom);
    t_trace = (trig_q.size() > 0) ? trig_q[0] : cyc;
    guard = 0;
    while (cyc < t_trace + 39 && guard < 100) begin idle(1); guard++; end
    check("pre_abort_nbits", 32'(obs_q.size()), 32'd5);
    do_reset();
    idle(60);
    check("abort_out_nbits", 32'(obs_q.size()), 32'd0);
    for (int i = 0; i < 31; i++) push($urandom);
    idle(5);
    check("refill_no_trig", 32'(trig_q.size()), 32'd0);
    push($urandom);
    idle(55);
    check("refill_nbits", 32'(obs_q.size()), 32'd16);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
